// File: rtl/lsu_controller.sv
// rtl/lsu_controller.sv - load/store sequencer: decode strobes to valid/ack bus transaction with stall
// Handles lane steering, load extension, misalignment, illegal funct3, bus error and timeout.
module lsu_controller #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic            stall,
  output logic            misaligned,
  output logic            access_fault,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_be,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;

  logic            w_access;
  logic            w_fn_ok;
  logic            w_mis;
  logic            w_go;
  logic [CW-1:0]   w_cnt_nxt;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_ext;

  assign w_access  = mem_read | mem_write;
  assign w_go      = w_access & w_fn_ok & ~w_mis;
  assign w_cnt_nxt = r_cnt + 1'b1;
  // stall is combinational so the core freezes in the very cycle the access is decoded
  assign stall     = ~rst & (((r_state == S_IDLE) & w_go) | (r_state == S_REQ));

  always_comb begin
    w_fn_ok = 1'b0;
    if (mem_write)
      w_fn_ok = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010);
    else
      w_fn_ok = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010) |
                (funct3 == 3'b100) | (funct3 == 3'b101);
  end

  always_comb begin
    w_mis = 1'b0;
    case (funct3[1:0])
      2'b01:   w_mis = addr[0];
      2'b10:   w_mis = (addr[1:0] != 2'b00);
      default: w_mis = 1'b0;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << addr[1:0];
          w_wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          w_be    = addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{store_data[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = store_data;
        end
      endcase
    end
  end

  always_comb begin
    w_byte = bus_rdata[7:0];
    case (r_off)
      2'b01:   w_byte = bus_rdata[15:8];
      2'b10:   w_byte = bus_rdata[23:16];
      2'b11:   w_byte = bus_rdata[31:24];
      default: w_byte = bus_rdata[7:0];
    endcase
    w_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {24'h000000, w_byte};
      3'b101:  w_ext = {16'h0000, w_half};
      default: w_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_funct3     <= 3'b000;
      r_off        <= 2'b00;
      load_data    <= '0;
      misaligned   <= 1'b0;
      access_fault <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_be       <= 4'b0000;
    end else begin
      misaligned   <= 1'b0;
      access_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (!w_fn_ok) begin
              access_fault <= 1'b1;
            end else if (w_mis) begin
              misaligned <= 1'b1;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= mem_write;
              bus_addr  <= {addr[XLEN-1:2], 2'b00};
              bus_wdata <= w_wdata;
              bus_be    <= w_be;
              r_funct3  <= funct3;
              r_off     <= addr[1:0];
              r_cnt     <= '0;
              r_state   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // an ack arriving in the expiry cycle wins over the timeout
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (bus_err)
              access_fault <= 1'b1;
            else if (!bus_we)
              load_data <= w_ext;
            r_state <= S_DONE;
          end else if (w_cnt_nxt == CW'(TIMEOUT_CYCLES)) begin
            bus_req      <= 1'b0;
            access_fault <= 1'b1;
            r_cnt        <= w_cnt_nxt;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// tb/tb_lsu_controller.sv - directed self-checking bench for lsu_controller
module tb_lsu_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, load_data;
  logic        stall, misaligned, access_fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;
  int          n_stall, n_req;
  logic        done_ok;
  int          req_seen;

  lsu_controller #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .store_data(store_data), .load_data(load_data),
    .stall(stall), .misaligned(misaligned), .access_fault(access_fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered 1 time unit after a rising edge in IDLE; returns 2 units after the DONE edge.
  task automatic run(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input logic [31:0] rd, input logic err,
                     input int ack_after);
    mem_write = wr; mem_read = !wr; funct3 = f3; addr = a; store_data = sd;
    n_stall = 0; n_req = 0; done_ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!stall && i > 0) begin
        done_ok = 1'b1;
        break;
      end
      if (stall) n_stall++;
      if (bus_req) begin
        n_req++;
        if (n_req == 1) begin
          obs_addr = bus_addr; obs_be = bus_be; obs_we = bus_we; obs_wdata = bus_wdata;
        end
        if (n_req > ack_after) begin
          bus_ack = 1'b1; bus_rdata = rd; bus_err = err;
        end
      end
      @(posedge clk);
      #1;
      bus_ack = 1'b0; bus_err = 1'b0;
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; store_data = 0;
    bus_ack = 0; bus_err = 0; bus_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    chk("rst_faults", {30'd0, misaligned, access_fault}, 32'd0);
    rst = 1'b0;
    tick();

    run(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1);
    chk("lw_done", {31'd0, done_ok}, 32'd1);
    chk("lw_stall_cycles", n_stall, 32'd3);
    chk("lw_bus_addr", obs_addr, 32'h100);
    chk("lw_bus_be", {28'd0, obs_be}, 32'hF);
    chk("lw_bus_we", {31'd0, obs_we}, 32'd0);
    chk("lw_load_data", load_data, 32'hDEADBEEF);
    chk("lw_done_req", {31'd0, bus_req}, 32'd0);
    tick();

    run(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 1'b0, 0);
    chk("lb_bus_addr", obs_addr, 32'h200);
    chk("lb_load_data", load_data, 32'hFFFFFF80);
    tick();
    run(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 1'b0, 0);
    chk("lbu_load_data", load_data, 32'h00000080);
    tick();
    run(1'b0, 3'b001, 32'h202, 32'h0, 32'h80FF1234, 1'b0, 0);
    chk("lh_load_data", load_data, 32'hFFFF80FF);
    tick();
    run(1'b0, 3'b101, 32'h200, 32'h0, 32'h80FF1234, 1'b0, 0);
    chk("lhu_load_data", load_data, 32'h00001234);
    tick();

    run(1'b1, 3'b001, 32'h12, 32'h0000ABCD, 32'h0, 1'b0, 0);
    chk("sh_done", {31'd0, done_ok}, 32'd1);
    chk("sh_bus_we", {31'd0, obs_we}, 32'd1);
    chk("sh_bus_be", {28'd0, obs_be}, 32'hC);
    chk("sh_bus_wdata", obs_wdata, 32'hABCDABCD);
    chk("sh_bus_addr", obs_addr, 32'h10);
    chk("sh_stall_cycles", n_stall, 32'd2);
    tick();
    run(1'b1, 3'b000, 32'h21, 32'h0000005A, 32'h0, 1'b0, 0);
    chk("sb_bus_be", {28'd0, obs_be}, 32'h2);
    chk("sb_bus_wdata", obs_wdata, 32'h5A5A5A5A);
    chk("store_keeps_load_data", load_data, 32'h00001234);
    tick();

    // misaligned LW: trap next cycle, no bus activity
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h102;
    #1;
    chk("mis_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    #1;
    chk("mis_pulse", {31'd0, misaligned}, 32'd1);
    chk("mis_fault", {31'd0, access_fault}, 32'd0);
    chk("mis_bus_req", {31'd0, bus_req}, 32'd0);
    @(posedge clk); #2;
    chk("mis_pulse_end", {31'd0, misaligned}, 32'd0);
    chk("mis_bus_req2", {31'd0, bus_req}, 32'd0);

    // illegal funct3 read
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b011; addr = 32'h100;
    #1;
    chk("ill_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    #1;
    chk("ill_fault", {31'd0, access_fault}, 32'd1);
    chk("ill_mis", {31'd0, misaligned}, 32'd0);
    chk("ill_bus_req", {31'd0, bus_req}, 32'd0);
    @(posedge clk); #2;
    chk("ill_fault_end", {31'd0, access_fault}, 32'd0);

    // illegal funct3 store (SBU-like encoding)
    @(posedge clk); #1;
    mem_write = 1'b1; funct3 = 3'b100; addr = 32'h100;
    @(posedge clk); #1;
    mem_write = 1'b0;
    #1;
    chk("ill_store_fault", {31'd0, access_fault}, 32'd1);
    chk("ill_store_req", {31'd0, bus_req}, 32'd0);
    @(posedge clk); #1;

    run(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 1'b0, 100);
    chk("to_done", {31'd0, done_ok}, 32'd1);
    chk("to_req_cycles", n_req, 32'd4);
    chk("to_fault", {31'd0, access_fault}, 32'd1);
    chk("to_load_data", load_data, 32'h00001234);
    tick();
    #1;
    chk("to_fault_end", {31'd0, access_fault}, 32'd0);

    run(1'b0, 3'b010, 32'h304, 32'h0, 32'hFFFFFFFF, 1'b1, 0);
    chk("err_fault", {31'd0, access_fault}, 32'd1);
    chk("err_load_data", load_data, 32'h00001234);
    tick();

    // reset mid-REQ with strobe still held
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h500;
    @(posedge clk); #2;
    chk("mid_req_bus_req", {31'd0, bus_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_load_data", load_data, 32'h0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    rst = 1'b0;
    tick();
    run(1'b1, 3'b010, 32'h400, 32'h11223344, 32'h0, 1'b0, 0);
    chk("post_rst_sw_done", {31'd0, done_ok}, 32'd1);
    chk("post_rst_sw_be", {28'd0, obs_be}, 32'hF);
    chk("post_rst_sw_wdata", obs_wdata, 32'h11223344);
    chk("post_rst_sw_addr", obs_addr, 32'h400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
